// File: rtl/dfx_router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dfx_router_pkg
// Description : Shared widths, beat type, segmenter state encoding and the
//               payload word generator for the 4-lane DFX router path.
// Revision    : 1.0 - initial release
// ============================================================================
package dfx_router_pkg;

    localparam int LANES        = 4;
    localparam int LANE_W       = 32;
    localparam int PAYLOAD_W    = 1024;
    localparam int ADDR_W       = 10;
    localparam int DFX_W        = 2;
    localparam int NUM_PORTS    = 1 << DFX_W;
    localparam int BEAT_W       = LANES * LANE_W;
    localparam int BEATS        = PAYLOAD_W / BEAT_W;
    localparam int RECV_W       = PAYLOAD_W + ADDR_W;
    localparam int HDR_ADDR_LSB = 10;

    localparam logic [3:0] c_payload_tag = 4'hA;

    // One beat on a hop: four lanes plus a flag marking the header beat
    typedef struct packed {
        logic                          hdr;
        logic [LANES-1:0][LANE_W-1:0]  lane;
    } beat_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HDR       = 2'd1,
        ST_DATA      = 2'd2,
        ST_WAIT_DONE = 2'd3
    } seg_state_t;

    // Payload word k of a packet built from the captured request fields
    function automatic logic [LANE_W-1:0] payload_word(
        input logic [DFX_W-1:0]  src_dfx,
        input logic [DFX_W-1:0]  dst_dfx,
        input logic [ADDR_W-1:0] scr_addr,
        input logic [5:0]        k
    );
        return {c_payload_tag, src_dfx, dst_dfx, scr_addr, 8'h00, k};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dfx_router_if.sv
`default_nettype none
// ============================================================================
// Module      : dfx_router_if
// Description : Router-to-reassembly hop: one-hot output-port valids, the
//               beat being carried and the receiver's registered ack pulse.
// Revision    : 1.0 - initial release
// ============================================================================
interface dfx_router_if;
    import dfx_router_pkg::*;

    logic [NUM_PORTS-1:0] port_valid;
    beat_t                beat;
    logic                 ack;

    modport master (output port_valid, output beat, input ack);
    modport slave  (input port_valid, input beat, output ack);

endinterface
`default_nettype wire

// File: rtl/dfx_reassembly.sv
`default_nettype none
// ============================================================================
// Module      : dfx_reassembly
// Description : Accepts header and data beats from any router port, acks each
//               one, rebuilds {payload, dst_addr} and publishes it with a
//               one-cycle valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module dfx_reassembly
    import dfx_router_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               rst_n,
    dfx_router_if.slave             hop,
    output logic                    o_recv_valid,
    output logic [RECV_W-1:0]       o_recv_data,
    output logic [DFX_W-1:0]        o_recv_dfx
);

    logic                          w_valid;
    logic [DFX_W-1:0]              w_port;
    logic                          r_ack;
    logic                          r_last;
    logic [2:0]                    r_cnt;
    logic [ADDR_W-1:0]             r_addr;
    logic [DFX_W-1:0]              r_port;
    logic [BEATS-1:0][BEAT_W-1:0]  r_payload;

    assign hop.ack = r_ack;

    // Collapse the one-hot port valids into a single valid and a port number
    always_comb begin
        w_valid = |hop.port_valid;
        w_port  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (hop.port_valid[p]) begin
                w_port = DFX_W'(p);
            end
        end
    end

    // Capture each beat once (not while its ack is out), then publish the packet
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ack        <= 1'b0;
            r_last       <= 1'b0;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_port       <= '0;
            r_payload    <= '0;
            o_recv_valid <= 1'b0;
            o_recv_data  <= '0;
            o_recv_dfx   <= '0;
        end else begin
            r_ack        <= 1'b0;
            r_last       <= 1'b0;
            o_recv_valid <= r_last;
            if (r_last) begin
                o_recv_data <= {r_payload, r_addr};
                o_recv_dfx  <= r_port;
            end
            if (w_valid && !r_ack) begin
                r_ack <= 1'b1;
                if (hop.beat.hdr) begin
                    r_addr <= hop.beat.lane[0][HDR_ADDR_LSB +: ADDR_W];
                    r_port <= w_port;
                    r_cnt  <= '0;
                end else begin
                    r_payload[r_cnt] <= hop.beat.lane;
                    r_cnt            <= r_cnt + 3'd1;
                    if (r_cnt == 3'(BEATS - 1)) begin
                        r_last <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dfx_router_system.sv
`default_nettype none
// ============================================================================
// Module      : dfx_router_system
// Description : Request capture, payload generation, segmentation into 4x32
//               beats, a registered steering router stage and the reassembly
//               unit for one packet at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module dfx_router_system
    import dfx_router_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic [DFX_W-1:0]   src_router,
    input  wire logic               router_start_req,
    input  wire logic [ADDR_W-1:0]  router_scr_addr,
    input  wire logic [ADDR_W-1:0]  router_dst_addr,
    input  wire logic [DFX_W-1:0]   router_src_dfx,
    input  wire logic [DFX_W-1:0]   router_dst_dfx,
    output logic                    recv_valid,
    output logic [RECV_W-1:0]       recv_data,
    output logic [DFX_W-1:0]        recv_dfx,
    output logic                    busy
);

    // Request capture
    logic                 r_prev_req;
    logic                 w_start;
    logic [DFX_W-1:0]     r_src_router;
    logic [DFX_W-1:0]     r_src_dfx;
    logic [DFX_W-1:0]     r_dst_dfx;
    logic [ADDR_W-1:0]    r_scr_addr;
    logic [ADDR_W-1:0]    r_dst_addr;

    // Segmenter
    seg_state_t           r_state;
    seg_state_t           w_state_nxt;
    logic [2:0]           r_beat_idx;
    logic [2:0]           w_beat_idx_nxt;
    logic                 w_seg_valid;
    beat_t                w_seg_beat;

    // Router stage
    logic                 r_seg_ack;
    logic                 w_accept;
    logic                 r_slot_valid;
    beat_t                r_slot_beat;
    logic [DFX_W-1:0]     r_slot_port;
    logic [NUM_PORTS-1:0] w_port_valid;

    dfx_router_if hop_if ();

    assign w_start = (r_state == ST_IDLE) && router_start_req && !r_prev_req;
    assign busy    = (r_state != ST_IDLE);

    // Rising-edge detect on start_req and latch the request fields on acceptance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev_req   <= 1'b1;
            r_src_router <= '0;
            r_src_dfx    <= '0;
            r_dst_dfx    <= '0;
            r_scr_addr   <= '0;
            r_dst_addr   <= '0;
        end else begin
            r_prev_req <= router_start_req;
            if (w_start) begin
                r_src_router <= src_router;
                r_src_dfx    <= router_src_dfx;
                r_dst_dfx    <= router_dst_dfx;
                r_scr_addr   <= router_scr_addr;
                r_dst_addr   <= router_dst_addr;
            end
        end
    end

    // Segmenter state and beat counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_beat_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_idx <= w_beat_idx_nxt;
        end
    end

    // Segmenter: hold each beat until its ack, then present the next one
    always_comb begin
        w_state_nxt    = r_state;
        w_beat_idx_nxt = r_beat_idx;
        w_seg_valid    = 1'b0;
        w_seg_beat     = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt    = ST_HDR;
                    w_beat_idx_nxt = '0;
                end
            end
            ST_HDR: begin
                w_seg_valid        = 1'b1;
                w_seg_beat.hdr     = 1'b1;
                w_seg_beat.lane[0] = {r_src_router, r_src_dfx, r_dst_dfx, 6'b0,
                                      r_dst_addr, 10'b0};
                if (r_seg_ack) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                w_seg_valid = 1'b1;
                for (int j = 0; j < LANES; j++) begin
                    w_seg_beat.lane[j] = payload_word(r_src_dfx, r_dst_dfx, r_scr_addr,
                                                      {1'b0, r_beat_idx, 2'(j)});
                end
                if (r_seg_ack) begin
                    if (r_beat_idx == 3'(BEATS - 1)) begin
                        w_state_nxt = ST_WAIT_DONE;
                    end else begin
                        w_beat_idx_nxt = r_beat_idx + 3'd1;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (recv_valid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The slot takes a new beat when empty or when its current beat is being acked
    assign w_accept = w_seg_valid && !r_seg_ack && (!r_slot_valid || hop_if.ack);

    // Router slot register and the ack pulse back to the segmenter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg_ack    <= 1'b0;
            r_slot_valid <= 1'b0;
            r_slot_beat  <= '0;
            r_slot_port  <= '0;
        end else begin
            r_seg_ack <= w_accept;
            if (w_accept) begin
                r_slot_valid <= 1'b1;
                r_slot_beat  <= w_seg_beat;
                r_slot_port  <= r_dst_dfx;
            end else if (hop_if.ack) begin
                r_slot_valid <= 1'b0;
            end
        end
    end

    // Steer the held beat onto the output port selected by dst_dfx
    always_comb begin
        w_port_valid = '0;
        if (r_slot_valid) begin
            w_port_valid[r_slot_port] = 1'b1;
        end
    end

    assign hop_if.port_valid = w_port_valid;
    assign hop_if.beat       = r_slot_beat;

    dfx_reassembly u_reassembly (
        .clk          (clk),
        .rst_n        (rst_n),
        .hop          (hop_if.slave),
        .o_recv_valid (recv_valid),
        .o_recv_data  (recv_data),
        .o_recv_dfx   (recv_dfx)
    );

endmodule
`default_nettype wire

// File: tb/tb_dfx_router_system.sv
`default_nettype none
// ============================================================================
// Module      : tb_dfx_router_system
// Description : Scoreboard bench for dfx_router_system. A request-level model
//               predicts accepted packets, their contents and timing; a
//               negedge monitor checks outputs against it every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dfx_router_system;
    import dfx_router_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [1:0]         src_router;
    logic               router_start_req;
    logic [9:0]         router_scr_addr;
    logic [9:0]         router_dst_addr;
    logic [1:0]         router_src_dfx;
    logic [1:0]         router_dst_dfx;
    logic               recv_valid;
    logic [RECV_W-1:0]  recv_data;
    logic [1:0]         recv_dfx;
    logic               busy;

    always #5 clk = ~clk;

    dfx_router_system dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .src_router       (src_router),
        .router_start_req (router_start_req),
        .router_scr_addr  (router_scr_addr),
        .router_dst_addr  (router_dst_addr),
        .router_src_dfx   (router_src_dfx),
        .router_dst_dfx   (router_dst_dfx),
        .recv_valid       (recv_valid),
        .recv_data        (recv_data),
        .recv_dfx         (recv_dfx),
        .busy             (busy)
    );

    // Observation copy of the router-to-reassembly hop
    dfx_router_if mon_if ();
    assign mon_if.port_valid = dut.hop_if.port_valid;
    assign mon_if.beat       = dut.hop_if.beat;
    assign mon_if.ack        = dut.hop_if.ack;

    typedef struct {
        logic [RECV_W-1:0] data;
        logic [1:0]        dfx;
        int                due;
    } exp_t;

    exp_t              sb_q[$];
    int                n_pass = 0;
    int                n_total = 0;
    int                edge_n = 0;
    bit                live = 1'b0;
    bit                m_prev = 1'b1;
    int                free_edge = 0;
    int                busy_lo = -1;
    int                busy_hi = -2;
    logic [RECV_W-1:0] held_data = '0;
    logic [1:0]        held_dfx = '0;
    bit                m_exp_busy;
    bit                m_exp_valid;

    // Expected packet from the request fields, written word by word
    function automatic logic [RECV_W-1:0] ref_packet(input logic [9:0] scr, input logic [9:0] dst,
                                                     input logic [1:0] sd, input logic [1:0] dd);
        logic [RECV_W-1:0] p;
        logic [31:0]       w;
        p       = '0;
        p[9:0]  = dst;
        for (int k = 0; k < 32; k++) begin
            w = 32'hA000_0000 + (32'(sd) << 26) + (32'(dd) << 24) + (32'(scr) << 14) + 32'(k);
            p[10 + 32*k +: 32] = w;
        end
        return p;
    endfunction

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    endtask

    task automatic check_pkt(input string name, input logic [RECV_W-1:0] act, input logic [RECV_W-1:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else if (act[9:0] !== exp[9:0]) begin
            $display("FAIL %s: addr got %03h expected %03h (edge %0d)", name, act[9:0], exp[9:0], edge_n);
        end else begin
            for (int k = 0; k < 32; k++) begin
                if (act[10 + 32*k +: 32] !== exp[10 + 32*k +: 32]) begin
                    $display("FAIL %s: word %0d got %08h expected %08h (edge %0d)", name, k,
                             act[10 + 32*k +: 32], exp[10 + 32*k +: 32], edge_n);
                    break;
                end
            end
        end
    endtask

    // Request-level model: reset, edge acceptance while idle, 20-cycle packet
    always @(posedge clk) begin
        edge_n++;
        if (!rst_n) begin
            live      = 1'b1;
            sb_q.delete();
            held_data = '0;
            held_dfx  = '0;
            m_prev    = 1'b1;
            free_edge = 0;
            busy_lo   = -1;
            busy_hi   = -2;
        end else begin
            if (edge_n >= free_edge && router_start_req && !m_prev) begin
                sb_q.push_back('{ref_packet(router_scr_addr, router_dst_addr, router_src_dfx, router_dst_dfx),
                                 router_dst_dfx, edge_n + 19});
                busy_lo   = edge_n;
                busy_hi   = edge_n + 19;
                free_edge = edge_n + 21;
            end
            m_prev = router_start_req;
        end
    end

    // Monitor: compare outputs with the model between clock edges
    always @(negedge clk) begin
        if (live) begin
            if (|mon_if.port_valid)
                check_val("port_steer", 64'(mon_if.port_valid),
                          (sb_q.size() > 0) ? 64'(4'b0001 << sb_q[0].dfx) : 64'd0);
            m_exp_busy  = (edge_n >= busy_lo) && (edge_n <= busy_hi);
            m_exp_valid = (sb_q.size() > 0) && (sb_q[0].due == edge_n);
            check_val("busy", 64'(busy), 64'(m_exp_busy));
            check_val("recv_valid", 64'(recv_valid), 64'(m_exp_valid));
            if ((recv_valid === 1'b1 || m_exp_valid) && sb_q.size() > 0) begin
                held_data = sb_q[0].data;
                held_dfx  = sb_q[0].dfx;
                void'(sb_q.pop_front());
            end
            check_pkt("recv_data", recv_data, held_data);
            check_val("recv_dfx", 64'(recv_dfx), 64'(held_dfx));
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: run exceeded 50000 cycles");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_fields(input logic [9:0] scr, input logic [9:0] dst,
                              input logic [1:0] sd, input logic [1:0] dd);
        router_scr_addr = scr;
        router_dst_addr = dst;
        router_src_dfx  = sd;
        router_dst_dfx  = dd;
        src_router      = 2'($urandom);
    endtask

    initial begin
        rst_n            = 1'b0;
        router_start_req = 1'b0;
        set_fields(10'h000, 10'h000, 2'd0, 2'd0);
        cyc(4);
        rst_n = 1'b1;
        cyc(5);

        // Basic packet, request held two cycles
        set_fields(10'h001, 10'h005, 2'd1, 2'd2);
        router_start_req = 1'b1;
        cyc(2);
        router_start_req = 1'b0;
        cyc(50);

        // Level held high for 500 cycles: one packet only
        set_fields(10'h000, 10'h007, 2'd1, 2'd3);
        router_start_req = 1'b1;
        cyc(3);
        set_fields(10'h155, 10'h2AA, 2'd2, 2'd0);
        cyc(497);
        router_start_req = 1'b0;
        cyc(5);

        // Second edge while busy is ignored
        set_fields(10'h0F0, 10'h123, 2'd3, 2'd1);
        router_start_req = 1'b1;
        cyc(2);
        router_start_req = 1'b0;
        cyc(2);
        set_fields(10'h00F, 10'h321, 2'd0, 2'd2);
        router_start_req = 1'b1;
        cyc(2);
        router_start_req = 1'b0;
        cyc(30);

        // Loopback
        set_fields(10'h3FF, 10'h1C3, 2'd0, 2'd0);
        router_start_req = 1'b1;
        cyc(1);
        router_start_req = 1'b0;
        cyc(30);

        // Reset mid-packet, then a fresh packet
        set_fields(10'h2B4, 10'h0AB, 2'd2, 2'd1);
        router_start_req = 1'b1;
        cyc(1);
        router_start_req = 1'b0;
        cyc(7);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        set_fields(10'h04C, 10'h3E1, 2'd1, 2'd1);
        router_start_req = 1'b1;
        cyc(1);
        router_start_req = 1'b0;
        cyc(30);

        // Random request levels and fields, fields changing while busy
        for (int it = 0; it < 60; it++) begin
            router_start_req = 1'b0;
            repeat ($urandom_range(0, 30)) begin
                set_fields(10'($urandom), 10'($urandom), 2'($urandom), 2'($urandom));
                cyc(1);
            end
            router_start_req = 1'b1;
            repeat ($urandom_range(1, 30)) begin
                if ($urandom_range(0, 7) == 0) router_start_req = ~router_start_req;
                set_fields(10'($urandom), 10'($urandom), 2'($urandom), 2'($urandom));
                cyc(1);
            end
        end
        router_start_req = 1'b0;
        cyc(30);

        check_val("queue_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dfx_router_system.md
Name: dfx_router_system

Overview:
- Top-level packet path of the 4-lane DFX router.
- A start request builds one 1024-bit payload packet addressed to a destination DFX region, then segments it into 4 lanes of 32-bit beats.
- The beats are carried through an ack-handshaked router stage to the reassembly unit, which rebuilds the 1034-bit packet {data, dst_addr} and presents it with a one-cycle valid pulse.

Parameters:
- LANES, 4, lanes per beat.
- LANE_W, 32, bits per lane.
- PAYLOAD_W, 1024, payload bits per packet.
- ADDR_W, 10, address width.

Ports:
- clk  in  1  single system clock
- rst_n  in  1  synchronous active-low reset
- src_router  in  2  id of the injecting router node (static); carried in the header beat, no routing effect
- router_start_req  in  1  request; a 0->1 transition while idle starts one packet
- router_scr_addr  in  10  source address, captured at acceptance
- router_dst_addr  in  10  destination address, captured at acceptance
- router_src_dfx  in  2  source DFX region id
- router_dst_dfx  in  2  destination DFX region id (router output port)
- recv_valid  out  1  one-cycle pulse when a packet is fully reassembled
- recv_data  out  1034  reassembled packet: [9:0]=dst_addr, [1033:10]=payload
- recv_dfx  out  2  output port (dst_dfx) the packet arrived on
- busy  out  1  high from acceptance through the recv_valid cycle

Behaviour:
- Reset is synchronous and active-low.
- Reset values:
  - recv_valid=0, recv_data=0, recv_dfx=0, busy=0.
  - All FSMs return to IDLE; any in-flight packet is discarded.
  - The start_req edge register resets to 1, so a level held high through reset release does not start a packet.
- Acceptance:
  - In IDLE with start_req=1 and prev_req=0, latch scr_addr, dst_addr, src_dfx, dst_dfx, src_router (cycle T).
  - busy=1 from T+1.
  - Edges that arrive while busy are ignored, not queued.
  - A level held high yields exactly one packet.
- Payload generation: word k (k=0..31) is placed at data[32k+31:32k] and equals {4'hA, src_dfx, dst_dfx, scr_addr, 8'h00, k[5:0]}.
- Segmenter FSM states: IDLE -> HDR -> DATA(beat 0..7) -> WAIT_DONE -> IDLE.
  - HDR beat: lane0 = {src_router, src_dfx, dst_dfx, 6'b0, dst_addr, 10'b0}; lanes 1-3 = 0.
  - DATA beat b: lane j = word 4b+j.
- Handshake on every hop:
  - The sender asserts valid with the beat and holds both stable until it samples ack=1.
  - ack is a one-cycle registered pulse from the receiver.
  - The next beat is presented the cycle after ack.
- Router stage:
  - Registered, one cycle per hop.
  - Steers beats to output port dst_dfx (0..3). Loopback (dst_dfx==src_dfx) is legal.
  - All four ports feed the single reassembly unit, which records the port in recv_dfx.
- Reassembly:
  - Stores header dst_addr into recv_data[9:0] and data beat b into payload bits [128b+127:128b].
  - After beat 7 it pulses recv_valid for one cycle.
  - recv_data and recv_dfx then hold until the next packet's recv_valid.
- Timing:
  - Each beat takes exactly 2 cycles (valid, ack); 9 beats total.
  - recv_valid is asserted in cycle T+20.
  - busy falls in cycle T+21; a new edge is accepted from T+21 onward.
- src_router has no effect on routing.

Decomposition:
- Shared package dfx_router_pkg holds:
  - LANES, LANE_W, PAYLOAD_W, ADDR_W;
  - beat type (4x32 plus a header flag);
  - FSM state enum;
  - the 4'hA payload tag constant.
- One natural sub-module: dfx_reassembly (beat receiver, ack generator, packet register).
- Request capture, payload generator, segmenter and router stage stay in the top.

Test Plan:
1. Reset held 4 cycles with start_req=0 -> recv_valid=0, busy=0, recv_data=0 throughout.
2. Edge at cycle 10 with scr=0x001, dst=0x005, src_dfx=1, dst_dfx=2, held 2 cycles -> exactly one recv_valid at T+20:
   - recv_data[9:0]=0x005, recv_dfx=2
   - word0=0xA6004000, word31=0xA600401F
3. Edge 50 cycles later with scr=0x000, dst=0x007, src_dfx=1, dst_dfx=3, held high 500 cycles -> exactly one packet:
   - recv_data[9:0]=0x007, recv_dfx=3
   - word0=0xA7000000, word5=0xA7000005
   - no second packet
4. Second edge at T+5, during busy -> ignored; only one recv_valid.
5. Loopback src_dfx=dst_dfx=0, scr=0x3FF -> recv_dfx=0, word0=0xA0FFC000.
6. rst_n low at T+8 mid-packet -> all outputs 0 next cycle, no recv_valid; a fresh edge after reset completes normally at +20.
